regfile_scoreboard: RTL

Parametrised multi-port integer register file for the processor core's decode stage. It provides three combinational read ports (two source operands plus an accumulator/destination read) and two write ports (ALU writeback and MAC/load writeback). It also holds a per-register busy scoreboard for hazard detection, with optional same-cycle write-to-read bypass. Register 0 reads as zero and is never busy.

---
 rtl/regfile_scoreboard.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with busy scoreboard and optional write bypass
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [DATA_WIDTH-1:0] accumData,
  output logic                  rs1Busy,
  output logic                  rs2Busy,
  output logic                  rdBusy,
  output logic                  hazard,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueRd,
  input  logic                  writeEnA,
  input  logic [ADDR_WIDTH-1:0] writeAddrA,
  input  logic [DATA_WIDTH-1:0] writeDataA,
  input  logic                  writeEnB,
  input  logic [ADDR_WIDTH-1:0] writeAddrB,
  input  logic [DATA_WIDTH-1:0] writeDataB
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  logic we_a;
  logic we_b;
  logic issue_en;

  assign we_a     = writeEnA && (writeAddrA != '0);
  assign we_b     = writeEnB && (writeAddrB != '0);
  assign issue_en = issueValid && (issueRd != '0);

  // Issue is applied last so a new outstanding producer keeps the bit set.
  always_comb begin
    busy_next = busy;
    if (we_a) busy_next[writeAddrA] = 1'b0;
    if (we_b) busy_next[writeAddrB] = 1'b0;
    if (issue_en) busy_next[issueRd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Port B is written after port A so it wins on an address collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (we_a) regs[writeAddrA] <= writeDataA;
      if (we_b) regs[writeAddrB] <= writeDataB;
      busy <= busy_next;
    end
  end

  logic [ADDR_WIDTH-1:0] raddr [3];
  logic [DATA_WIDTH-1:0] rdata [3];
  logic [2:0]            rbusy;

  assign raddr[0] = rs1;
  assign raddr[1] = rs2;
  assign raddr[2] = rd;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = regs[raddr[p]];
      rbusy[p] = busy[raddr[p]];
      if (BYPASS) begin
        if (we_b && (writeAddrB == raddr[p])) begin
          rdata[p] = writeDataB;
          rbusy[p] = 1'b0;
        end else if (we_a && (writeAddrA == raddr[p])) begin
          rdata[p] = writeDataA;
          rbusy[p] = 1'b0;
        end
      end
      // Bypassed write data must not leak out while reset is held.
      if (reset || (raddr[p] == '0)) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign readData1 = rdata[0];
  assign readData2 = rdata[1];
  assign accumData = rdata[2];
  assign rs1Busy   = rbusy[0];
  assign rs2Busy   = rbusy[1];
  assign rdBusy    = rbusy[2];
  assign hazard    = |rbusy;

endmodule
